// File: rtl/sine_deltas_cordic.sv
// sine_deltas_cordic: 32-bit phase increment -> Q31 unit rotation {cos, sin} for the GXSM sine oscillator.
// Latency: M_AXIS_DELTAS_tvalid rises N_ITER+2 clocks after the accepting S handshake (one CORDIC stage per clock).
// Backpressure: S_tready low while busy; result held in DONE until M_tready (sticky valid when SINE_DELTAS_HOLD_EN).
//
// Ports:
//   aclk, areset                      clock (125 MHz), asynchronous active-high reset
//   S_AXIS_PHASE_tdata/tvalid/tready  phase increment, unsigned, 2^32 == 2*pi
//   M_AXIS_DELTAS_tdata/tvalid/tready [63:32] cos(dphi) Q31, [31:0] sin(dphi) Q31
//
// Optional macro SINE_DELTAS_HOLD_EN: tvalid becomes sticky after the first result,
// M_tready is ignored and DONE lasts a single cycle.
module sine_deltas_cordic #(
    parameter int N_ITER = 31,   // micro-rotations, 16..31
    parameter int GUARD  = 2     // extra integer bits in the x/y datapath
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] S_AXIS_PHASE_tdata,
    input  logic        S_AXIS_PHASE_tvalid,
    output logic        S_AXIS_PHASE_tready,
    output logic [63:0] M_AXIS_DELTAS_tdata,
    output logic        M_AXIS_DELTAS_tvalid,
    input  logic        M_AXIS_DELTAS_tready
);

    localparam int W = 32 + GUARD;

    // CORDIC gain compensation 0.6072529350 * 2^31, preloaded into x so no
    // post-scaling multiplier is needed.
    localparam logic signed [W-1:0] K_INIT   = W'(32'sd1304065748);
    localparam logic signed [W-1:0] SAT_POS  = {{(GUARD + 1){1'b0}}, {31{1'b1}}};
    localparam logic signed [W-1:0] SAT_NEG  = -SAT_POS;
    localparam logic [4:0]          ITER_LAST = 5'(N_ITER - 1);
    localparam logic [63:0]         IDENTITY = {32'h7FFF_FFFF, 32'h0000_0000};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [31:0]         phase_q;
    logic                neg_q;
    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic signed [31:0]  z_q;
    logic [4:0]          iter_q;
    logic [63:0]         tdata_q;
    logic                tvalid_q;

    // atan(2^-i) in phase units (2^32 == 2*pi), rounded.
    function automatic logic [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'h2000_0000;
            5'd1:    atan_rom = 32'h12E4_051E;
            5'd2:    atan_rom = 32'h09FB_385B;
            5'd3:    atan_rom = 32'h0511_11D4;
            5'd4:    atan_rom = 32'h028B_0D43;
            5'd5:    atan_rom = 32'h0145_D7E1;
            5'd6:    atan_rom = 32'h00A2_F61E;
            5'd7:    atan_rom = 32'h0051_7C55;
            5'd8:    atan_rom = 32'h0028_BE53;
            5'd9:    atan_rom = 32'h0014_5F2F;
            5'd10:   atan_rom = 32'h000A_2F98;
            5'd11:   atan_rom = 32'h0005_17CC;
            5'd12:   atan_rom = 32'h0002_8BE6;
            5'd13:   atan_rom = 32'h0001_45F3;
            5'd14:   atan_rom = 32'h0000_A2FA;
            5'd15:   atan_rom = 32'h0000_517D;
            5'd16:   atan_rom = 32'h0000_28BE;
            5'd17:   atan_rom = 32'h0000_145F;
            5'd18:   atan_rom = 32'h0000_0A30;
            5'd19:   atan_rom = 32'h0000_0518;
            5'd20:   atan_rom = 32'h0000_028C;
            5'd21:   atan_rom = 32'h0000_0146;
            5'd22:   atan_rom = 32'h0000_00A3;
            5'd23:   atan_rom = 32'h0000_0051;
            5'd24:   atan_rom = 32'h0000_0029;
            5'd25:   atan_rom = 32'h0000_0014;
            5'd26:   atan_rom = 32'h0000_000A;
            5'd27:   atan_rom = 32'h0000_0005;
            5'd28:   atan_rom = 32'h0000_0003;
            5'd29:   atan_rom = 32'h0000_0001;
            5'd30:   atan_rom = 32'h0000_0001;
            default: atan_rom = 32'h0000_0000;
        endcase
    endfunction

    // Symmetric clamp: -2^31 is never produced so the oscillator's
    // complex multiply stays symmetric around zero.
    function automatic logic [31:0] sat_q31(input logic signed [W-1:0] v);
        if (v > SAT_POS) begin
            sat_q31 = 32'h7FFF_FFFF;
        end else if (v < SAT_NEG) begin
            sat_q31 = 32'h8000_0001;
        end else begin
            sat_q31 = v[31:0];
        end
    endfunction

    // Quadrant fold: phases in (pi/2, 3pi/2) are rotated by pi and the
    // result negated, leaving |z| <= pi/2 inside the CORDIC convergence range.
    logic                fold_neg;
    logic signed [31:0]  z_fold;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [31:0]  atan_i;
    logic                rot_pos;
    logic signed [W-1:0] x_fin;
    logic signed [W-1:0] y_fin;

    assign fold_neg = phase_q[31] ^ phase_q[30];
    assign z_fold   = fold_neg ? $signed(phase_q - 32'h8000_0000) : $signed(phase_q);
    assign x_sh     = x_q >>> iter_q;
    assign y_sh     = y_q >>> iter_q;
    assign atan_i   = $signed(atan_rom(iter_q));
    assign rot_pos  = ~z_q[31];
    assign x_fin    = neg_q ? -x_q : x_q;
    assign y_fin    = neg_q ? -y_q : y_q;

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (S_AXIS_PHASE_tvalid) begin
                    state_d = FOLD;
                end
            end
            FOLD: begin
                state_d = ITER;
            end
            ITER: begin
                if (iter_q == ITER_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef SINE_DELTAS_HOLD_EN
                state_d = IDLE;
`else
                // First DONE cycle loads the result; leave only after the
                // registered valid has been accepted.
                if (tvalid_q && M_AXIS_DELTAS_tready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase_q  <= '0;
            neg_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            iter_q   <= '0;
            tdata_q  <= IDENTITY;
            tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (S_AXIS_PHASE_tvalid) begin
                        phase_q <= S_AXIS_PHASE_tdata;
                    end
                end
                FOLD: begin
                    z_q    <= z_fold;
                    neg_q  <= fold_neg;
                    x_q    <= K_INIT;
                    y_q    <= '0;
                    iter_q <= '0;
                end
                ITER: begin
                    if (rot_pos) begin
                        x_q <= x_q - y_sh;
                        y_q <= y_q + x_sh;
                        z_q <= z_q - atan_i;
                    end else begin
                        x_q <= x_q + y_sh;
                        y_q <= y_q - x_sh;
                        z_q <= z_q + atan_i;
                    end
                    iter_q <= iter_q + 5'd1;
                end
                DONE: begin
`ifdef SINE_DELTAS_HOLD_EN
                    tdata_q  <= {sat_q31(x_fin), sat_q31(y_fin)};
                    tvalid_q <= 1'b1;
`else
                    if (!tvalid_q) begin
                        tdata_q  <= {sat_q31(x_fin), sat_q31(y_fin)};
                        tvalid_q <= 1'b1;
                    end else if (M_AXIS_DELTAS_tready) begin
                        tvalid_q <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Gated with areset so no phase word is taken while reset is held.
    assign S_AXIS_PHASE_tready  = (state_q == IDLE) && !areset;
    assign M_AXIS_DELTAS_tdata  = tdata_q;
    assign M_AXIS_DELTAS_tvalid = tvalid_q;

endmodule

// File: tb/tb_sine_deltas_cordic.sv
// tb_sine_deltas_cordic: randomized and directed checks of sine_deltas_cordic against a real-valued model.
// Latency: expects tvalid N_ITER+2 = 33 clocks after each S handshake.
// Backpressure: exercises a held M_tready with a second phase word pending.
module tb_sine_deltas_cordic;

    localparam int     LAT     = 33;
    localparam longint TOL     = 64;
    localparam longint Q31_MAX = 64'sd2147483647;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    int errs   = 0;
    int checks = 0;

    always #4 aclk = ~aclk;

    sine_deltas_cordic dut (
        .aclk                 (aclk),
        .areset               (areset),
        .S_AXIS_PHASE_tdata   (s_tdata),
        .S_AXIS_PHASE_tvalid  (s_tvalid),
        .S_AXIS_PHASE_tready  (s_tready),
        .M_AXIS_DELTAS_tdata  (m_tdata),
        .M_AXIS_DELTAS_tvalid (m_tvalid),
        .M_AXIS_DELTAS_tready (m_tready)
    );

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // round(f(2*pi*ph/2^32) * (2^31-1))
    function automatic longint ref_q31(input logic [31:0] ph, input bit want_cos);
        real a;
        real r;
        a = 6.283185307179586 * real'(longint'(ph)) / 4294967296.0;
        r = want_cos ? $cos(a) : $sin(a);
        r = r * 2147483647.0;
        return longint'($rtoi($floor(r + 0.5)));
    endfunction

    // Present a phase word and return at the negedge after the accepting edge.
    task automatic send_phase(input logic [31:0] ph);
        int n;
        @(negedge aclk);
        s_tdata  = ph;
        s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check_val("s_ready_wait", longint'(s_tready), 1, 0);
        @(posedge aclk);
        @(negedge aclk);
        s_tvalid = 1'b0;
    endtask

    // Count clocks until tvalid; also notes any tdata change while not valid.
    task automatic wait_valid(output int lat, output bit moved);
        logic [63:0] prev;
        prev  = m_tdata;
        moved = 1'b0;
        lat   = 0;
        do begin
            @(negedge aclk);
            lat++;
            if (!m_tvalid && m_tdata != prev) moved = 1'b1;
        end while (!m_tvalid && lat < 200);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ph, input int lat, input bit moved,
                                output longint c, output longint s);
        check_val({tag, "_lat"}, longint'(lat), LAT, 0);
        check_val({tag, "_hold"}, longint'(moved), 0, 0);
        check_val({tag, "_vld"}, longint'(m_tvalid), 1, 0);
        c = longint'($signed(m_tdata[63:32]));
        s = longint'($signed(m_tdata[31:0]));
        check_val({tag, "_cos"}, c, ref_q31(ph, 1'b1), TOL);
        check_val({tag, "_sin"}, s, ref_q31(ph, 1'b0), TOL);
        check_val({tag, "_nomin"},
                  longint'((m_tdata[63:32] == 32'h8000_0000) || (m_tdata[31:0] == 32'h8000_0000)), 0, 0);
    endtask

    // One full transaction with M_tready high.
    task automatic run_one(input logic [31:0] ph, input string tag, output longint c, output longint s);
        int lat;
        bit moved;
        send_phase(ph);
        wait_valid(lat, moved);
        check_result(tag, ph, lat, moved, c, s);
        @(negedge aclk);
        check_val({tag, "_vld_drop"}, longint'(m_tvalid), 0, 0);
        check_val({tag, "_rdy_back"}, longint'(s_tready), 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        longint c;
        longint s;
        longint norm;
        int lat;
        bit moved;
        logic [63:0] snap;
        logic [31:0] ph;

        areset   = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        #1 areset = 1'b1;
        #2;
        check_val("rst_tdata", longint'(m_tdata), 64'h7FFF_FFFF_0000_0000, 0);
        check_val("rst_tvalid", longint'(m_tvalid), 0, 0);
        check_val("rst_s_tready", longint'(s_tready), 0, 0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check_val("idle_s_tready", longint'(s_tready), 1, 0);

        // Directed phases
        run_one(32'h0000_0000, "ph0", c, s);
        check_val("ph0_cos_abs", c, Q31_MAX, TOL);
        check_val("ph0_sin_abs", s, 0, TOL);
        run_one(32'h0555_5555, "pi24", c, s);
        check_val("pi24_cos_abs", c, 2129111627, TOL);
        check_val("pi24_sin_abs", s, 280302863, TOL);
        run_one(32'h4000_0000, "q1", c, s);
        check_val("q1_cos_abs", c, 0, TOL);
        check_val("q1_sin_abs", s, Q31_MAX, TOL);
        run_one(32'h8000_0000, "q2", c, s);
        check_val("q2_cos_abs", c, -Q31_MAX, TOL);
        check_val("q2_sin_abs", s, 0, TOL);
        run_one(32'hC000_0000, "q3", c, s);
        check_val("q3_cos_abs", c, 0, TOL);
        check_val("q3_sin_abs", s, -Q31_MAX, TOL);
        run_one(32'h7FFF_FFFF, "edge_hi", c, s);
        run_one(32'hFFFF_FFFF, "edge_top", c, s);

        // Backpressure with a second word pending
        m_tready = 1'b0;
        send_phase(32'h0555_5555);
        wait_valid(lat, moved);
        check_result("bp_a", 32'h0555_5555, lat, moved, c, s);
        snap     = m_tdata;
        s_tdata  = 32'h4000_0000;
        s_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            check_val("bp_tdata_stable", longint'(m_tdata != snap), 0, 0);
            check_val("bp_tvalid_stable", longint'(m_tvalid), 1, 0);
            check_val("bp_s_tready_low", longint'(s_tready), 0, 0);
        end
        m_tready = 1'b1;
        @(negedge aclk);
        check_val("bp_vld_drop", longint'(m_tvalid), 0, 0);
        check_val("bp_rdy_back", longint'(s_tready), 1, 0);
        @(negedge aclk);
        check_val("bp_b_taken", longint'(s_tready), 0, 0);
        s_tvalid = 1'b0;
        wait_valid(lat, moved);
        check_result("bp_b", 32'h4000_0000, lat, moved, c, s);
        @(negedge aclk);

        // Reset in the middle of ITER
        send_phase(32'h1234_5678);
        repeat (10) @(negedge aclk);
        areset = 1'b1;
        #1;
        check_val("midrst_tdata", longint'(m_tdata), 64'h7FFF_FFFF_0000_0000, 0);
        check_val("midrst_tvalid", longint'(m_tvalid), 0, 0);
        check_val("midrst_s_tready", longint'(s_tready), 0, 0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check_val("midrst_idle", longint'(s_tready), 1, 0);
        run_one(32'h2000_0000, "pi4", c, s);
        check_val("pi4_cos_abs", c, 1518500249, TOL);
        check_val("pi4_sin_abs", s, 1518500249, TOL);

        // Random sweep
        for (int k = 0; k < 1000; k++) begin
            ph = $urandom;
            run_one(ph, "rnd", c, s);
            norm = c * c + s * s;
            check_val("rnd_norm", norm, longint'(1) <<< 62, longint'(1) <<< 40);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
